// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR step/overflow functions, defaults and monitor state type
package lfsr_pkg;

    localparam logic [31:0] DEF_TAPS   = 32'hB8;
    localparam logic [31:0] DEF_OVF_UP = 32'h80;
    localparam logic [31:0] DEF_OVF_DN = 32'h01;

    typedef enum logic [1:0] {S_SYNC, S_CHECK, S_HALT} mon_state_t;

    // Width-generic helpers on 32-bit containers; w is the live width (1..32).
    function automatic logic [31:0] lfsr_mask(input int w);
        return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    endfunction

    // XNOR feedback shifted in at the LSB; all-zeros is legal, all-ones locks up.
    function automatic logic [31:0] lfsr_next_up(input logic [31:0] c, input logic [31:0] taps, input int w);
        logic [31:0] m;
        m = lfsr_mask(w);
        return ((c << 1) & m) | {31'd0, ~^(c & taps & m)};
    endfunction

    // Inverse of the up step: the old MSB is recovered from the new LSB and the
    // remaining taps, which after the shift sit one position higher (assumes
    // taps[w-1] is set, as for every maximal-length mask).
    function automatic logic [31:0] lfsr_next_down(input logic [31:0] c, input logic [31:0] taps, input int w);
        logic [31:0] m;
        m = lfsr_mask(w);
        return ((c & m) >> 1) | ({31'd0, ~^(c & {taps[30:0], 1'b1} & m)} << (w - 1));
    endfunction

    function automatic logic lfsr_ovf(input logic [31:0] c, input logic up, input logic [31:0] ovf_up, input logic [31:0] ovf_dn);
        return up ? (c == ovf_up) : (c == ovf_dn);
    endfunction

endpackage

// File: rtl/lfsr_stat_counter.sv
// lfsr_stat_counter: saturating statistics counter with increment 0..2
//   clk, rst : clock, async active-high reset
//   clear    : synchronous zero
//   inc      : amount to add this cycle (0..2)
//   value    : current count; nxt : saturated value+inc (pre-clear)
module lfsr_stat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [1:0]   inc,
    output logic [W-1:0] value,
    output logic [W-1:0] nxt
);

    logic [W:0] sum;

    assign sum = {1'b0, value} + (W+1)'(inc);
    assign nxt = sum[W] ? '1 : sum[W-1:0];

    always_ff @(posedge clk or posedge rst)
        if (rst) value <= '0;
        else     value <= clear ? '0 : nxt;

endmodule

// File: rtl/lfsr_updown_monitor.sv
// lfsr_updown_monitor: passive step/overflow checker for lfsr_updown
//   clk, reset         : clock, async active-high reset
//   clear              : synchronous restart (stats to 0, back to S_SYNC)
//   enable, up_down    : counter controls as driven to the counter
//   count, overflow    : counter outputs
//   expected           : registered prediction for the next sample
//   step_err, ovf_err  : one-cycle mismatch pulses, one cycle after the sample
//   err_count          : saturating error total
//   wrap_count         : saturating count of observed enabled overflows
//   halted, active     : in S_HALT / in S_CHECK
module lfsr_updown_monitor
    import lfsr_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   TAPS    = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0]   OVF_UP  = WIDTH'(DEF_OVF_UP),
    parameter logic [WIDTH-1:0]   OVF_DN  = WIDTH'(DEF_OVF_DN),
    parameter int                 ERR_W   = 8,
    parameter int                 CNT_W   = 16,
    parameter int                 MAX_ERR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] count,
    input  logic             overflow,
    output logic [WIDTH-1:0] expected,
    output logic             step_err,
    output logic             ovf_err,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic             halted,
    output logic             active
);

    mon_state_t       state, state_d;
    logic [31:0]      c32;
    logic [WIDTH-1:0] pred;
    logic             ovf_exp, step_mis, ovf_mis, checking;
    logic [1:0]       err_inc, wrap_inc;
    logic [ERR_W-1:0] err_next;
    logic [CNT_W-1:0] wrap_next;

    assign c32      = 32'(count);
    // Prediction is always built from the observed count, so a single corrupt
    // sample yields a single error instead of a cascade.
    assign pred     = !enable ? count :
                      WIDTH'(up_down ? lfsr_next_up(c32, 32'(TAPS), WIDTH)
                                     : lfsr_next_down(c32, 32'(TAPS), WIDTH));
    assign ovf_exp  = lfsr_ovf(c32, up_down, 32'(OVF_UP), 32'(OVF_DN));
    assign step_mis = count != expected;
    assign ovf_mis  = overflow != ovf_exp;
    assign checking = state == S_CHECK;
    assign err_inc  = checking ? {1'b0, step_mis} + {1'b0, ovf_mis} : 2'd0;
    assign wrap_inc = {1'b0, checking & overflow & enable};
    assign halted   = state == S_HALT;
    assign active   = checking;

    lfsr_stat_counter #(.W(ERR_W)) u_err (
        .clk   (clk),
        .rst   (reset),
        .clear (clear),
        .inc   (err_inc),
        .value (err_count),
        .nxt   (err_next)
    );

    lfsr_stat_counter #(.W(CNT_W)) u_wrap (
        .clk   (clk),
        .rst   (reset),
        .clear (clear),
        .inc   (wrap_inc),
        .value (wrap_count),
        .nxt   (wrap_next)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_SYNC;
        else       state <= state_d;

    // Halt decision uses the post-increment total so a double error can cross MAX_ERR.
    always_comb begin
        state_d = state;
        if (clear)                                            state_d = S_SYNC;
        else if (state == S_SYNC)                             state_d = S_CHECK;
        else if (checking && int'(err_next) >= MAX_ERR)       state_d = S_HALT;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            expected <= '0;
            step_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            step_err <= !clear && checking && step_mis;
            ovf_err  <= !clear && checking && ovf_mis;
            if (!clear && !halted) expected <= pred;
        end

endmodule

// File: tb/tb_lfsr_updown_monitor.sv
// tb_lfsr_updown_monitor: directed self-checking bench for lfsr_updown_monitor
module tb_lfsr_updown_monitor;

    logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
    logic        enable = 1'b0, up_down = 1'b0, overflow = 1'b0;
    logic [7:0]  count = 8'h00;
    logic [7:0]  expected;
    logic        step_err, ovf_err, halted, active;
    logic [7:0]  err_count;
    logic [15:0] wrap_count;
    int          checks = 0, errors = 0;

    logic [7:0] up_seq  [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    logic [7:0] up_pred [5] = '{8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};

    always #5 clk = ~clk;

    lfsr_updown_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (enable),
        .up_down    (up_down),
        .count      (count),
        .overflow   (overflow),
        .expected   (expected),
        .step_err   (step_err),
        .ovf_err    (ovf_err),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .halted     (halted),
        .active     (active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic ud, input logic [7:0] c, input logic ov);
        enable = en; up_down = ud; count = c; overflow = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_expected", 32'(expected), 32'h00);
        check("rst_active",   32'(active),   32'h0);
        check("rst_err",      32'(err_count), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: idle at zero
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_active",   32'(active),   32'h1);
        check("idle_expected", 32'(expected), 32'h00);
        check("idle_steperr",  32'(step_err), 32'h0);
        repeat (9) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_steperr9", 32'(step_err),  32'h0);
        check("idle_err",      32'(err_count), 32'h0);

        // 2: clean up sequence
        do_reset;
        step(1'b1, 1'b1, 8'h00, 1'b0);
        check("up_expected0", 32'(expected), 32'h01);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, up_seq[i], 1'b0);
            check("up_steperr",   32'(step_err), 32'h0);
            check("up_expected",  32'(expected), 32'(up_pred[i]));
        end
        check("up_err", 32'(err_count), 32'h0);

        // 3: one corrupt sample, then resync on the observed value
        do_reset;
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b0);
        step(1'b1, 1'b1, 8'h05, 1'b0);
        check("bad_steperr",  32'(step_err),  32'h1);
        check("bad_err",      32'(err_count), 32'h1);
        check("bad_expected", 32'(expected),  32'h0B);
        step(1'b1, 1'b1, 8'h0B, 1'b0);
        check("resync_steperr",  32'(step_err),  32'h0);
        check("resync_err",      32'(err_count), 32'h1);
        check("resync_expected", 32'(expected),  32'h16);

        // 4: overflow mismatch and wrap counting
        do_reset;
        step(1'b0, 1'b1, 8'h80, 1'b1);
        check("ovf_sync_wrap", 32'(wrap_count), 32'h0);
        step(1'b0, 1'b1, 8'h80, 1'b0);
        check("ovf_ovferr",  32'(ovf_err),    32'h1);
        check("ovf_steperr", 32'(step_err),   32'h0);
        check("ovf_err",     32'(err_count),  32'h1);
        check("ovf_wrap0",   32'(wrap_count), 32'h0);
        step(1'b1, 1'b1, 8'h80, 1'b1);
        check("wrap_ovferr",   32'(ovf_err),    32'h0);
        check("wrap_count",    32'(wrap_count), 32'h1);
        check("wrap_err",      32'(err_count),  32'h1);
        check("wrap_expected", 32'(expected),   32'h00);

        // 5: direction change and double error
        do_reset;
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b1);
        check("dn_ovferr",   32'(ovf_err),    32'h0);
        check("dn_expected", 32'(expected),   32'h00);
        check("dn_wrap",     32'(wrap_count), 32'h1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("dn_expected2", 32'(expected), 32'h80);
        step(1'b1, 1'b0, 8'h55, 1'b1);
        check("dbl_steperr",  32'(step_err),   32'h1);
        check("dbl_ovferr",   32'(ovf_err),    32'h1);
        check("dbl_err",      32'(err_count),  32'h2);
        check("dbl_wrap",     32'(wrap_count), 32'h2);
        check("dbl_expected", 32'(expected),   32'h2A);

        // 6: halt at MAX_ERR, async reset, clear
        do_reset;
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        check("pre_halt_err",    32'(err_count), 32'h3);
        check("pre_halt_halted", 32'(halted),    32'h0);
        step(1'b0, 1'b1, 8'h66, 1'b0);
        check("halt_steperr", 32'(step_err),  32'h1);
        check("halt_err",     32'(err_count), 32'h4);
        check("halt_halted",  32'(halted),    32'h1);
        check("halt_active",  32'(active),    32'h0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        check("frozen_steperr", 32'(step_err),  32'h0);
        check("frozen_err",     32'(err_count), 32'h4);
        check("frozen_halted",  32'(halted),    32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_expected", 32'(expected),  32'h00);
        check("async_err",      32'(err_count), 32'h0);
        check("async_halted",   32'(halted),    32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'h11, 1'b1);
        check("dbl2_err", 32'(err_count), 32'h2);
        step(1'b0, 1'b1, 8'h22, 1'b1);
        check("cross_err",    32'(err_count),  32'h4);
        check("cross_halted", 32'(halted),     32'h1);
        check("cross_wrap",   32'(wrap_count), 32'h0);
        clear = 1'b1;
        step(1'b0, 1'b1, 8'h22, 1'b0);
        clear = 1'b0;
        check("clr_halted", 32'(halted),    32'h0);
        check("clr_active", 32'(active),    32'h0);
        check("clr_err",    32'(err_count), 32'h0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        check("clr_sync_active", 32'(active),   32'h1);
        check("clr_sync_steperr", 32'(step_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
